// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: exception > (load FIFO vs ALU, round-robin),
// with a 2-entry load FIFO and a per-register pending-write scoreboard.
module rf_write_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int FLAGS_W = 32
) (
    input  logic                 sysclk,
    input  logic                 nreset,
    input  logic                 exc_valid,
    input  logic [ADDR_W-1:0]    exc_addr,
    input  logic [DATA_W-1:0]    exc_data,
    input  logic [FLAGS_W-1:0]   exc_flags,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_addr,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 alu_flags_en,
    input  logic [FLAGS_W-1:0]   alu_flags,
    output logic [ADDR_W-1:0]    RF_Addr_Write,
    output logic [DATA_W-1:0]    RF_Bus_Write,
    output logic                 RF_Load_Write,
    output logic [FLAGS_W-1:0]   RF_Flags_Write,
    output logic                 RF_Load_Flags,
    output logic                 RF_PSR_W_Sel,
    output logic [2**ADDR_W-1:0] pend
);

    logic [ADDR_W-1:0] fifo_addr [2];
    logic [DATA_W-1:0] fifo_data [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              rr;
    logic              out_load;

    logic fifo_empty;
    logic grant_alu;
    logic grant_fifo;
    logic push;
    logic pop;

    assign fifo_empty = (count == 2'd0);
    assign mem_ready  = (count < 2'd2);
    assign grant_alu  = alu_valid & ~exc_valid & (fifo_empty | ~rr);
    assign grant_fifo = ~exc_valid & ~fifo_empty & (~alu_valid | rr);
    assign alu_ready  = grant_alu;
    assign push       = mem_valid & mem_ready;
    assign pop        = grant_fifo;

    // FIFO storage carries no reset; validity comes solely from count.
    always_ff @(posedge sysclk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mem_addr;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge sysclk or negedge nreset) begin
        if (!nreset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            rr     <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // On contention rr is left pointing at whichever side lost.
            if (!exc_valid && alu_valid && !fifo_empty)
                rr <= grant_alu;
        end
    end

    always_ff @(posedge sysclk or negedge nreset) begin
        if (!nreset) begin
            RF_Addr_Write  <= '0;
            RF_Bus_Write   <= '0;
            RF_Load_Write  <= 1'b0;
            RF_Flags_Write <= '0;
            RF_Load_Flags  <= 1'b0;
            RF_PSR_W_Sel   <= 1'b0;
            out_load       <= 1'b0;
        end else begin
            RF_Load_Write <= exc_valid | grant_alu | grant_fifo;
            RF_Load_Flags <= exc_valid | (grant_alu & alu_flags_en);
            out_load      <= grant_fifo;
            if (exc_valid) begin
                RF_Addr_Write  <= exc_addr;
                RF_Bus_Write   <= exc_data;
                RF_Flags_Write <= exc_flags;
                RF_PSR_W_Sel   <= 1'b1;
            end else if (grant_alu) begin
                RF_Addr_Write  <= alu_addr;
                RF_Bus_Write   <= alu_data;
                RF_Flags_Write <= alu_flags;
                RF_PSR_W_Sel   <= 1'b0;
            end else if (grant_fifo) begin
                RF_Addr_Write  <= fifo_addr[rd_ptr];
                RF_Bus_Write   <= fifo_data[rd_ptr];
            end
        end
    end

    // Pending loads: valid FIFO slots in pop order, plus a load in the output stage.
    always_comb begin
        pend = '0;
        for (int i = 0; i < 2; i++) begin
            if (2'(i) < count)
                pend[fifo_addr[rd_ptr ^ 1'(i)]] = 1'b1;
        end
        if (out_load)
            pend[RF_Addr_Write] = 1'b1;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random traffic,
// compared against a queue-based model of the arbitration rules.
module tb_rf_write_arbiter;

    logic        sysclk = 1'b0;
    logic        nreset;
    logic        exc_valid, mem_valid, alu_valid, alu_flags_en;
    logic [3:0]  exc_addr, mem_addr, alu_addr;
    logic [31:0] exc_data, mem_data, alu_data;
    logic [31:0] exc_flags, alu_flags;
    logic        mem_ready, alu_ready;
    logic [3:0]  RF_Addr_Write;
    logic [31:0] RF_Bus_Write, RF_Flags_Write;
    logic        RF_Load_Write, RF_Load_Flags, RF_PSR_W_Sel;
    logic [15:0] pend;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_rr;
    logic        m_lw, m_lf, m_psr, m_outload;
    logic [3:0]  m_addr;
    logic [31:0] m_data, m_flags;

    rf_write_arbiter #(.ADDR_W(4), .DATA_W(32), .FLAGS_W(32)) dut (
        .sysclk(sysclk), .nreset(nreset),
        .exc_valid(exc_valid), .exc_addr(exc_addr), .exc_data(exc_data), .exc_flags(exc_flags),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .alu_flags_en(alu_flags_en), .alu_flags(alu_flags),
        .RF_Addr_Write(RF_Addr_Write), .RF_Bus_Write(RF_Bus_Write), .RF_Load_Write(RF_Load_Write),
        .RF_Flags_Write(RF_Flags_Write), .RF_Load_Flags(RF_Load_Flags), .RF_PSR_W_Sel(RF_PSR_W_Sel),
        .pend(pend)
    );

    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] modelPend();
        logic [15:0] p = '0;
        foreach (q[i]) p[q[i].a] = 1'b1;
        if (m_outload) p[m_addr] = 1'b1;
        return p;
    endfunction

    task automatic modelReset();
        q.delete();
        m_rr = 1'b0; m_lw = 1'b0; m_lf = 1'b0; m_psr = 1'b0; m_outload = 1'b0;
        m_addr = '0; m_data = '0; m_flags = '0;
    endtask

    task automatic idleInputs();
        exc_valid = 0; mem_valid = 0; alu_valid = 0; alu_flags_en = 0;
        exc_addr = 0; mem_addr = 0; alu_addr = 0;
        exc_data = 0; mem_data = 0; alu_data = 0; exc_flags = 0; alu_flags = 0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance the model, check after the edge.
    task automatic applyStimulus(
        input logic ev, input logic [3:0] ea, input logic [31:0] ed, input logic [31:0] ef,
        input logic mv, input logic [3:0] ma, input logic [31:0] md,
        input logic av, input logic [3:0] aa, input logic [31:0] ad,
        input logic afe, input logic [31:0] af);
        int   winner;
        logic exp_ready;
        @(negedge sysclk);
        exc_valid = ev; exc_addr = ea; exc_data = ed; exc_flags = ef;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad; alu_flags_en = afe; alu_flags = af;
        #1;
        exp_ready = (q.size() < 2);
        if (ev)                       winner = 1;
        else if (q.size() > 0 && av)  winner = m_rr ? 2 : 3;
        else if (q.size() > 0)        winner = 2;
        else if (av)                  winner = 3;
        else                          winner = 0;
        checkOutput("mem_ready", 64'(mem_ready), 64'(exp_ready));
        checkOutput("alu_ready", 64'(alu_ready), 64'(winner == 3));
        checkOutput("pend", 64'(pend), 64'(modelPend()));
        if (!ev && q.size() > 0 && av) m_rr = (winner == 3);
        m_lw = (winner != 0);
        m_lf = (winner == 1) || (winner == 3 && afe);
        m_outload = (winner == 2);
        case (winner)
            1: begin m_addr = ea; m_data = ed; m_flags = ef; m_psr = 1'b1; end
            2: begin m_addr = q[0].a; m_data = q[0].d; void'(q.pop_front()); end
            3: begin m_addr = aa; m_data = ad; m_flags = af; m_psr = 1'b0; end
            default: ;
        endcase
        if (mv && exp_ready) q.push_back('{a: ma, d: md});
        @(posedge sysclk);
        #1;
        checkOutput("load_write", 64'(RF_Load_Write), 64'(m_lw));
        checkOutput("load_flags", 64'(RF_Load_Flags), 64'(m_lf));
        checkOutput("addr_write", 64'(RF_Addr_Write), 64'(m_addr));
        checkOutput("bus_write", 64'(RF_Bus_Write), 64'(m_data));
        if (m_lf) begin
            checkOutput("flags_write", 64'(RF_Flags_Write), 64'(m_flags));
            checkOutput("psr_sel", 64'(RF_PSR_W_Sel), 64'(m_psr));
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        @(negedge sysclk);
        nreset = 1'b0;
        exc_valid = 1; mem_valid = 1; alu_valid = 1; alu_flags_en = 1;
        #1;
        checkOutput("rst_alu_ready", 64'(alu_ready), 64'd0);
        repeat (2) @(posedge sysclk);
        #1;
        checkOutput("rst_load_write", 64'(RF_Load_Write), 64'd0);
        checkOutput("rst_bus", 64'(RF_Bus_Write), 64'd0);
        checkOutput("rst_pend", 64'(pend), 64'd0);
        checkOutput("rst_mem_ready", 64'(mem_ready), 64'd1);
        @(negedge sysclk);
        idleInputs();
        nreset = 1'b1;
        modelReset();
    endtask

    initial begin
        nreset = 1'b1;
        idleInputs();
        modelReset();
        doReset();

        // Lone ALU write with flag update
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 32'h000000FF, 1, 32'h10);
        checkOutput("lone_addr", 64'(RF_Addr_Write), 64'd3);
        checkOutput("lone_bus", 64'(RF_Bus_Write), 64'hFF);
        checkOutput("lone_psr", 64'(RF_PSR_W_Sel), 64'd0);
        idleCycle();

        // ALU and load contending every cycle
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 0, 0, 0, 1, 4'd5, 32'h1234, 1, 4'(i + 8), 32'(i), 0, 0);
        repeat (3) idleCycle();

        // Exception preempts both lower sources
        applyStimulus(1, 4'd14, 32'h8, 32'hD3, 1, 4'd6, 32'h55, 1, 4'd7, 32'h66, 1, 32'h1);
        checkOutput("exc_addr", 64'(RF_Addr_Write), 64'd14);
        checkOutput("exc_psr", 64'(RF_PSR_W_Sel), 64'd1);
        checkOutput("exc_flags", 64'(RF_Flags_Write), 64'hD3);
        repeat (3) idleCycle();

        // FIFO fills behind a sustained exception, then drains in order
        doReset();
        for (int i = 1; i <= 3; i++)
            applyStimulus(1, 4'd14, 32'h8, 32'hD3, 1, 4'(i), 32'(i * 16), 0, 0, 0, 0, 0);
        checkOutput("full_pend", 64'(pend), 64'h0006);
        checkOutput("full_ready", 64'(mem_ready), 64'd0);
        idleCycle();
        checkOutput("drain1_addr", 64'(RF_Addr_Write), 64'd1);
        idleCycle();
        checkOutput("drain2_addr", 64'(RF_Addr_Write), 64'd2);
        checkOutput("drain2_pend", 64'(pend), 64'h0004);
        idleCycle();
        checkOutput("drain_pend", 64'(pend), 64'h0000);

        // Reset asserted with a full FIFO and a live output write
        applyStimulus(1, 4'd9, 32'h9, 32'h9, 1, 4'd1, 32'h1, 0, 0, 0, 0, 0);
        applyStimulus(1, 4'd9, 32'h9, 32'h9, 1, 4'd2, 32'h2, 0, 0, 0, 0, 0);
        @(negedge sysclk);
        idleInputs();
        nreset = 1'b0;
        #1;
        checkOutput("midrst_pend", 64'(pend), 64'd0);
        checkOutput("midrst_lw", 64'(RF_Load_Write), 64'd0);
        checkOutput("midrst_ready", 64'(mem_ready), 64'd1);
        @(negedge sysclk);
        nreset = 1'b1;
        modelReset();
        repeat (2) idleCycle();

        // Random traffic
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 7) == 0, 4'($urandom), $urandom, $urandom,
                          1'($urandom), 4'($urandom), $urandom,
                          1'($urandom), 4'($urandom), $urandom,
                          1'($urandom), $urandom);
        repeat (3) idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
